// File: rtl/dmem_pkg.sv
// Shared types and constants for the handshaked data-memory responder.
package dmem_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// Word RAM: synchronous write port, combinational read port, no reset of contents.
module dmem_array #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_W-1:0]     rdata_c
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Handshaked, wait-stated data memory for the MEM stage.
// Define DMEM_ALIGN_CHECK_EN to flag and suppress misaligned (address bit 0 set) accesses.
module dmem_responder #(
  parameter int unsigned DATA_W      = dmem_pkg::DATA_W,
  parameter int unsigned DEPTH_LOG2  = 8,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_read,
  input  logic                        req_write,
  input  logic [dmem_pkg::ADDR_W-1:0] req_address,
  input  logic [DATA_W-1:0]           req_writeData,
  output logic                        resp_valid,
  output logic [DATA_W-1:0]           resp_dataRead,
  output logic                        resp_error
);

  import dmem_pkg::*;

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

  state_t                  state, state_next;
  logic [WAIT_CNT_W-1:0]   cnt, cnt_next;
  logic [DEPTH_LOG2-1:0]   lat_idx;
  logic [DATA_W-1:0]       lat_wdata;
  logic                    lat_write;
  logic                    accept;
  logic [DEPTH_LOG2-1:0]   req_idx;
  logic [DEPTH_LOG2-1:0]   rd_idx;
  logic [DATA_W-1:0]       rd_data_c;
  logic                    err_next;
  logic                    store_ok;
  logic                    we;
  logic                    ready_d, valid_d, error_d;
  logic [DATA_W-1:0]       data_d;
  logic                    unused_addr_bits;

  assign accept  = req_valid & (req_read | req_write);
  assign req_idx = req_address[DEPTH_LOG2:1];
  assign unused_addr_bits = ^{req_address[ADDR_W-1:DEPTH_LOG2+1], req_address[0]};

  // Response data is registered on entry to RESP, so the read index must be live in IDLE.
  assign rd_idx = (state == IDLE) ? req_idx : lat_idx;

`ifdef DMEM_ALIGN_CHECK_EN
  logic lat_bit0;

  always_ff @(posedge clock) begin
    if (state == IDLE && accept) lat_bit0 <= req_address[0];
  end

  assign err_next = (state == IDLE) ? req_address[0] : lat_bit0;
  assign store_ok = ~lat_bit0;
`else
  assign err_next = 1'b0;
  assign store_ok = 1'b1;
`endif

  assign we = (state == RESP) & lat_write & store_ok & ~reset;

  dmem_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clock   (clock),
    .we      (we),
    .waddr   (lat_idx),
    .wdata   (lat_wdata),
    .raddr   (rd_idx),
    .rdata_c (rd_data_c)
  );

  // Next state, wait counter and next registered outputs.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_STATES > 0) begin
            state_next = WAIT;
            cnt_next   = WAIT_LOAD;
          end else begin
            state_next = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) state_next = RESP;
        else           cnt_next   = cnt - WAIT_CNT_W'(1);
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    ready_d = (state_next == IDLE);
    valid_d = (state_next == RESP);
    error_d = valid_d & err_next;
    data_d  = (valid_d && !err_next) ? rd_data_c : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_dataRead <= '0;
      resp_error    <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      req_ready     <= ready_d;
      resp_valid    <= valid_d;
      resp_dataRead <= data_d;
      resp_error    <= error_d;
    end
  end

  // Request capture; inputs are don't-care once accepted.
  always_ff @(posedge clock) begin
    if (state == IDLE && accept) begin
      lat_idx   <= req_idx;
      lat_wdata <= req_writeData;
      lat_write <= req_write;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: WAIT_STATES=2 vector table plus WAIT_STATES=0 instance.
module tb_dmem_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_read, req_write;
  logic [15:0] req_address, req_writeData;
  logic        req_ready, resp_valid, resp_error;
  logic [15:0] resp_dataRead;

  logic        z_req_valid, z_req_read, z_req_write;
  logic [15:0] z_req_address, z_req_writeData;
  logic        z_req_ready, z_resp_valid, z_resp_error;
  logic [15:0] z_resp_dataRead;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  dmem_responder #(.DATA_W(16), .DEPTH_LOG2(8), .WAIT_STATES(2)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_read(req_read), .req_write(req_write), .req_address(req_address),
    .req_writeData(req_writeData), .resp_valid(resp_valid),
    .resp_dataRead(resp_dataRead), .resp_error(resp_error)
  );

  dmem_responder #(.DATA_W(16), .DEPTH_LOG2(8), .WAIT_STATES(0)) dut0 (
    .clock(clock), .reset(reset), .req_valid(z_req_valid), .req_ready(z_req_ready),
    .req_read(z_req_read), .req_write(z_req_write), .req_address(z_req_address),
    .req_writeData(z_req_writeData), .resp_valid(z_resp_valid),
    .resp_dataRead(z_resp_dataRead), .resp_error(z_resp_error)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        chk;
    logic [15:0] expd;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expd);
    checks++;
    if (act !== expd) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expd);
    end
  endtask

  // One transaction on the WAIT_STATES=2 instance; lat is cycles from accept edge to resp_valid.
  task automatic txn(input logic rd, input logic wr, input logic [15:0] addr,
                     input logic [15:0] wdata, output logic [15:0] data,
                     output logic err, output int lat, output int busy);
    int w = 0;
    @(negedge clock);
    while (!req_ready && w < 20) begin
      @(negedge clock);
      w++;
    end
    req_valid = 1'b1; req_read = rd; req_write = wr;
    req_address = addr; req_writeData = wdata;
    @(posedge clock);
    #1;
    req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
    lat = 0; busy = 0; data = '0; err = 1'b0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clock);
      if (!req_ready) busy++;
      if (resp_valid) begin
        lat  = k;
        data = resp_dataRead;
        err  = resp_error;
      end
    end
    if (w >= 20) lat = -1;
  endtask

  task automatic z_prime(input logic [15:0] addr, input logic [15:0] wdata);
    @(negedge clock);
    z_req_valid = 1'b1; z_req_write = 1'b1; z_req_address = addr; z_req_writeData = wdata;
    @(posedge clock);
    #1;
    z_req_valid = 1'b0; z_req_write = 1'b0;
    @(negedge clock);
    check("ws0_store_resp_valid", 32'(z_resp_valid), 32'd1);
    check("ws0_store_ready_low", 32'(z_req_ready), 32'd0);
  endtask

  logic [15:0] d;
  logic        e;
  int          lat, busy;

  initial begin
    reset = 1'b1;
    req_valid = 0; req_read = 0; req_write = 0; req_address = '0; req_writeData = '0;
    z_req_valid = 0; z_req_read = 0; z_req_write = 0; z_req_address = '0; z_req_writeData = '0;

    vecs[0] = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000};
    vecs[1] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'hBEEF};
    vecs[2] = '{1'b0, 1'b1, 16'h0020, 16'h1234, 1'b0, 16'h0000};
    vecs[3] = '{1'b1, 1'b1, 16'h0020, 16'h5678, 1'b1, 16'h1234};
    vecs[4] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1, 16'h5678};
    vecs[5] = '{1'b0, 1'b1, 16'h0204, 16'hA5A5, 1'b0, 16'h0000};
    vecs[6] = '{1'b1, 1'b0, 16'h0004, 16'h0000, 1'b1, 16'hA5A5};
    vecs[7] = '{1'b0, 1'b1, 16'h0030, 16'h1111, 1'b0, 16'h0000};
    vecs[8] = '{1'b0, 1'b1, 16'h0010, 16'h0001, 1'b1, 16'hBEEF};
    vecs[9] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'h0001};

    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_resp_data", 32'(resp_dataRead), 32'd0);
    check("reset_resp_error", 32'(resp_error), 32'd0);
    check("reset_ws0_ready", 32'(z_req_ready), 32'd1);

    // req_valid without read or write must be ignored
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("ignored_ready", 32'(req_ready), 32'd1);
      check("ignored_valid", 32'(resp_valid), 32'd0);
    end
    req_valid = 1'b0;

    for (int i = 0; i < 10; i++) begin
      txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, d, e, lat, busy);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
      check($sformatf("vec%0d_ready_low", i), 32'(busy), 32'd3);
      check($sformatf("vec%0d_error", i), 32'(e), 32'd0);
      if (vecs[i].chk) check($sformatf("vec%0d_data", i), 32'(d), 32'(vecs[i].expd));
    end
    @(negedge clock);
    check("post_resp_valid_low", 32'(resp_valid), 32'd0);
    check("post_resp_data_zero", 32'(resp_dataRead), 32'd0);

    // reset during WAIT aborts the store
    req_valid = 1'b1; req_write = 1'b1; req_address = 16'h0030; req_writeData = 16'h7777;
    @(posedge clock);
    #1 req_valid = 1'b0; req_write = 1'b0;
    @(negedge clock);
    check("wait_ready_low", 32'(req_ready), 32'd0);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("abort_wait_valid", 32'(resp_valid), 32'd0);
    check("abort_wait_data", 32'(resp_dataRead), 32'd0);
    check("abort_wait_error", 32'(resp_error), 32'd0);
    check("abort_wait_ready", 32'(req_ready), 32'd1);
    txn(1'b1, 1'b0, 16'h0030, 16'h0000, d, e, lat, busy);
    check("abort_wait_readback", 32'(d), 32'h1111);

    // reset during RESP also suppresses the store
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_address = 16'h0030; req_writeData = 16'h2222;
    @(posedge clock);
    #1 req_valid = 1'b0; req_write = 1'b0;
    repeat (3) @(negedge clock);
    check("resp_cycle_valid", 32'(resp_valid), 32'd1);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    txn(1'b1, 1'b0, 16'h0030, 16'h0000, d, e, lat, busy);
    check("abort_resp_readback", 32'(d), 32'h1111);

    // halfword-select bit set
    txn(1'b0, 1'b1, 16'h0031, 16'hFFFF, d, e, lat, busy);
    check("odd_latency", 32'(lat), 32'd3);
`ifdef DMEM_ALIGN_CHECK_EN
    check("odd_error", 32'(e), 32'd1);
    check("odd_data", 32'(d), 32'd0);
    txn(1'b1, 1'b0, 16'h0030, 16'h0000, d, e, lat, busy);
    check("odd_readback", 32'(d), 32'h1111);
`else
    check("odd_error", 32'(e), 32'd0);
    check("odd_data", 32'(d), 32'h1111);
    txn(1'b1, 1'b0, 16'h0030, 16'h0000, d, e, lat, busy);
    check("odd_readback", 32'(d), 32'hFFFF);
`endif
    check("even_error", 32'(e), 32'd0);

    // WAIT_STATES=0: back-to-back reads with req_valid held high
    z_prime(16'h0000, 16'h00AA);
    z_prime(16'h0002, 16'h00BB);
    @(negedge clock);
    z_req_valid = 1'b1; z_req_read = 1'b1; z_req_address = 16'h0000;
    check("b2b_c0_ready", 32'(z_req_ready), 32'd1);
    check("b2b_c0_valid", 32'(z_resp_valid), 32'd0);
    @(posedge clock);
    #1 z_req_address = 16'h0002;
    @(negedge clock);
    check("b2b_c1_valid", 32'(z_resp_valid), 32'd1);
    check("b2b_c1_data", 32'(z_resp_dataRead), 32'h00AA);
    check("b2b_c1_ready", 32'(z_req_ready), 32'd0);
    @(negedge clock);
    check("b2b_c2_ready", 32'(z_req_ready), 32'd1);
    check("b2b_c2_valid", 32'(z_resp_valid), 32'd0);
    @(posedge clock);
    #1 z_req_valid = 1'b0; z_req_read = 1'b0;
    @(negedge clock);
    check("b2b_c3_valid", 32'(z_resp_valid), 32'd1);
    check("b2b_c3_data", 32'(z_resp_dataRead), 32'h00BB);
    @(negedge clock);
    check("b2b_c4_ready", 32'(z_req_ready), 32'd1);
    check("b2b_c4_valid", 32'(z_resp_valid), 32'd0);
    check("b2b_c4_data", 32'(z_resp_dataRead), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the MEM stage's load/store requests. It replaces the single-cycle data memory with a handshaked, wait-stated word store.
- It accepts one request at a time from the pipeline, holds it for a programmable number of wait states, and commits the write or returns read data.
- It returns a one-cycle response pulse.
- The MEM stage stalls on req_ready/resp_valid; the branch path is unaffected.

Parameters:
- DATA_W, 16, data word width
- DEPTH_LOG2, 8, log2 of word count (256 words); word index = req_address[DEPTH_LOG2:1]
- WAIT_STATES, 2, extra cycles between accept and response; legal range 0..15

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request this cycle
- req_read  in  1  load request (MemRead)
- req_write  in  1  store request (MemWrite)
- req_address  in  16  byte address; bit 0 is the halfword select, upper bits are ignored
- req_writeData  in  DATA_W  store data
- resp_valid  out  1  one-cycle response pulse
- resp_dataRead  out  DATA_W  read data, valid while resp_valid is high
- resp_error  out  1  misaligned access flag (see Optional Feature)

Behaviour:
- Reset: synchronous and active-high.
  - Forces state IDLE, wait counter 0, req_ready=1 on the following cycle.
  - resp_valid=0, resp_dataRead=0, resp_error=0.
  - Memory contents are not cleared.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - A request is accepted when req_valid & (req_read | req_write).
  - On accept, address, writeData, read and write are latched into registers. Inputs are don't-care afterwards.
  - req_valid with both read and write low is ignored; no state change.
  - On accept, go to WAIT if WAIT_STATES>0, else go to RESP.
- WAIT:
  - req_ready=0.
  - The counter loads WAIT_STATES-1 on entry and decrements each cycle.
  - Go to RESP when the counter reaches 0.
- RESP:
  - req_ready=0, resp_valid=1 for exactly one cycle.
  - resp_dataRead = mem[index] as it was before this cycle (read-before-write).
  - If the latched write is set, mem[index] <= latched writeData at the end of this cycle.
  - Then go to IDLE.
- Latency: accept on edge N puts resp_valid high in cycle N+1+WAIT_STATES.
- Throughput: one request per 2+WAIT_STATES cycles.
- read and write both set: treated as a store; the old word is returned on resp_dataRead.
- Write-only response: resp_dataRead still carries the pre-write word; the MEM stage ignores it.
- resp_dataRead is 0 whenever resp_valid=0.
- There is no response backpressure. The requester must sample in the RESP cycle.
- Address aliasing: bits above DEPTH_LOG2 are ignored; index wraps modulo 2^DEPTH_LOG2.
- Reset in WAIT or RESP aborts the transaction. A store is committed only if the RESP cycle completes without reset asserted.
- Request held across RESP (req_valid still high on return to IDLE): it is accepted as a new transaction. The requester deasserts req_valid after acceptance to avoid replay.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined:
  - A latched address with bit 0 = 1 is misaligned.
  - In RESP: no store is committed, resp_dataRead=0, resp_error=1 for the RESP cycle only.
  - Aligned accesses behave as above with resp_error=0.
- Undefined:
  - req_address[0] is ignored and resp_error is tied to 0.
  - No misalignment logic is synthesised.

Decomposition:
- Package dmem_pkg:
  - state enum {IDLE, WAIT, RESP}
  - DATA_W and ADDR_W=16 constants
  - WAIT_CNT_W=4
- Sub-module dmem_array:
  - Synchronous word RAM, 2^DEPTH_LOG2 x DATA_W.
  - One combinational read port and one write port with write enable.
  - Instantiated once by dmem_responder.
- FSM and wait counter stay in the top module.

Test Plan:
- Store then load, WAIT_STATES=2:
  - Stimulus: write 0xBEEF to 0x0010, then read 0x0010.
  - Store: resp_valid pulses 3 cycles after accept.
  - Load: resp_dataRead=0xBEEF in its RESP cycle; req_ready low for 3 cycles per transaction.
- WAIT_STATES=0:
  - Stimulus: back-to-back reads of 0x0000 and 0x0002, req_valid held high.
  - Response 1 cycle after each accept; accepts spaced 2 cycles apart.
- Read and write both set:
  - Stimulus: address 0x0020 holding 0x1234, writeData=0x5678.
  - resp_dataRead=0x1234; a subsequent read returns 0x5678.
- Alias:
  - Stimulus: write 0xA5A5 to 0x0204 (DEPTH_LOG2=8), then read 0x0004.
  - Read returns 0xA5A5.
- Reset mid-op:
  - Stimulus: accept write 0x7777 to 0x0030, assert reset in the WAIT cycle.
  - Outputs are 0 the next cycle; a subsequent read of 0x0030 returns the prior value.
- DMEM_ALIGN_CHECK_EN:
  - Stimulus: write 0xFFFF to 0x0031.
  - resp_error=1 and resp_dataRead=0 in RESP; a read of 0x0030 shows the value unchanged.
